execute_stage: RTL and testbench

EXECUTE_STAGE -- requirements
Module: execute_stage

---
 rtl/execute_stage.sv | 134 +++++++++++++
 tb/tb_execute_stage.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/execute_stage.sv
// ---------------------------------------------------------------------------
// execute_stage
//   Two-register execute slice of the integer pipeline. The ID/EX register
//   captures the decoded instruction, a combinational ALU evaluates it, and
//   the EX/MEM register presents the registered result downstream.
//
// Ports
//   i_clk        clock, all state updates on the rising edge
//   i_rst_n      synchronous active-low reset, clears both stages to bubble
//   i_valid      incoming decode-stage instruction is valid
//   i_alu_ctl    ALU operation code (ALU_CTL_* below)
//   i_src_a      operand A
//   i_src_b      operand B (register value or immediate)
//   i_rd         destination register index
//   i_reg_write  instruction writes rd
//   i_stall      hold ID/EX, inject a bubble into EX/MEM
//   i_flush      squash the instruction entering ID/EX (overrides stall)
//   o_valid      EX/MEM entry valid
//   o_result     registered ALU result
//   o_zero       registered flag, result equals zero
//   o_rd         registered destination index
//   o_reg_write  registered write enable (never set for x0 or invalid entries)
// ---------------------------------------------------------------------------
module execute_stage #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  input  logic [2:0]      i_alu_ctl,
  input  logic [XLEN-1:0] i_src_a,
  input  logic [XLEN-1:0] i_src_b,
  input  logic [4:0]      i_rd,
  input  logic            i_reg_write,
  input  logic            i_stall,
  input  logic            i_flush,
  output logic            o_valid,
  output logic [XLEN-1:0] o_result,
  output logic            o_zero,
  output logic [4:0]      o_rd,
  output logic            o_reg_write
);

  // ALU operation encodings shared with the decode stage.
  localparam logic [2:0] ALU_CTL_ADD         = 3'd0;
  localparam logic [2:0] ALU_CTL_SUB         = 3'd1;
  localparam logic [2:0] ALU_CTL_AND         = 3'd2;
  localparam logic [2:0] ALU_CTL_OR          = 3'd3;
  localparam logic [2:0] ALU_CTL_SLT         = 3'd4;
  localparam logic [2:0] ALU_CTL_U_EXTENSION = 3'd5;

  // ID/EX register
  logic            idex_valid_reg;
  logic [2:0]      idex_alu_ctl_reg;
  logic [XLEN-1:0] idex_src_a_reg;
  logic [XLEN-1:0] idex_src_b_reg;
  logic [4:0]      idex_rd_reg;
  logic            idex_reg_write_reg;

  // EX/MEM register
  logic            exmem_valid_reg;
  logic [XLEN-1:0] exmem_result_reg;
  logic            exmem_zero_reg;
  logic [4:0]      exmem_rd_reg;
  logic            exmem_reg_write_reg;

  // Combinational ALU and EX/MEM load values
  logic [XLEN-1:0] alu_result_next;
  logic            alu_zero_next;
  logic            reg_write_next;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_flush) begin
      // Reset and flush both leave a bubble; flush wins over stall.
      idex_valid_reg     <= 1'b0;
      idex_alu_ctl_reg   <= '0;
      idex_src_a_reg     <= '0;
      idex_src_b_reg     <= '0;
      idex_rd_reg        <= '0;
      idex_reg_write_reg <= 1'b0;
    end else if (!i_stall) begin
      idex_valid_reg     <= i_valid;
      idex_alu_ctl_reg   <= i_alu_ctl;
      idex_src_a_reg     <= i_src_a;
      idex_src_b_reg     <= i_src_b;
      idex_rd_reg        <= i_rd;
      idex_reg_write_reg <= i_reg_write;
    end
  end

  always_comb begin
    alu_result_next = '0;
    case (idex_alu_ctl_reg)
      ALU_CTL_ADD:         alu_result_next = idex_src_a_reg + idex_src_b_reg;
      ALU_CTL_SUB:         alu_result_next = idex_src_a_reg - idex_src_b_reg;
      ALU_CTL_AND:         alu_result_next = idex_src_a_reg & idex_src_b_reg;
      ALU_CTL_OR:          alu_result_next = idex_src_a_reg | idex_src_b_reg;
      ALU_CTL_SLT:         alu_result_next = {{(XLEN-1){1'b0}},
                             ($signed(idex_src_a_reg) < $signed(idex_src_b_reg))};
      ALU_CTL_U_EXTENSION: alu_result_next = idex_src_b_reg;
      default:             alu_result_next = '0;
    endcase
  end

  assign alu_zero_next = (alu_result_next == '0);
  // Writes to x0 and from invalid entries are dropped here so downstream
  // stages can trust o_reg_write without re-qualifying it.
  assign reg_write_next = idex_valid_reg && idex_reg_write_reg && (idex_rd_reg != 5'd0);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || (i_stall && !i_flush)) begin
      // A stalled ID/EX entry is still sitting there next cycle, so forwarding
      // it now would emit it twice.
      exmem_valid_reg     <= 1'b0;
      exmem_result_reg    <= '0;
      exmem_zero_reg      <= 1'b0;
      exmem_rd_reg        <= '0;
      exmem_reg_write_reg <= 1'b0;
    end else begin
      exmem_valid_reg     <= idex_valid_reg;
      exmem_result_reg    <= alu_result_next;
      exmem_zero_reg      <= alu_zero_next;
      exmem_rd_reg        <= idex_rd_reg;
      exmem_reg_write_reg <= reg_write_next;
    end
  end

  assign o_valid     = exmem_valid_reg;
  assign o_result    = exmem_result_reg;
  assign o_zero      = exmem_zero_reg;
  assign o_rd        = exmem_rd_reg;
  assign o_reg_write = exmem_reg_write_reg;

endmodule

// File: tb/tb_execute_stage.sv
// ---------------------------------------------------------------------------
// tb_execute_stage
//   Directed-vector bench for execute_stage. Inputs are driven and outputs are
//   sampled on the falling edge; every expected value is a hand-computed
//   constant from the stimulus tables below.
// ---------------------------------------------------------------------------
module tb_execute_stage;

  localparam logic [2:0] ADD  = 3'd0;
  localparam logic [2:0] SUB  = 3'd1;
  localparam logic [2:0] AND_ = 3'd2;
  localparam logic [2:0] OR_  = 3'd3;
  localparam logic [2:0] SLT  = 3'd4;
  localparam logic [2:0] UEXT = 3'd5;

  logic        clk;
  logic        rst_n;
  logic        valid;
  logic [2:0]  alu_ctl;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic [4:0]  rd;
  logic        reg_write;
  logic        stall;
  logic        flush;
  logic        o_valid;
  logic [31:0] o_result;
  logic        o_zero;
  logic [4:0]  o_rd;
  logic        o_reg_write;

  int total_cnt = 0;
  int bad_cnt   = 0;

  execute_stage #(.XLEN(32)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_valid     (valid),
    .i_alu_ctl   (alu_ctl),
    .i_src_a     (src_a),
    .i_src_b     (src_b),
    .i_rd        (rd),
    .i_reg_write (reg_write),
    .i_stall     (stall),
    .i_flush     (flush),
    .o_valid     (o_valid),
    .o_result    (o_result),
    .o_zero      (o_zero),
    .o_rd        (o_rd),
    .o_reg_write (o_reg_write)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    if (obs !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic v, input logic [31:0] res,
                           input logic z, input logic [4:0] d, input logic rw);
    check_eq({tag, ".valid"},     {31'd0, o_valid},     {31'd0, v});
    check_eq({tag, ".result"},    o_result,             res);
    check_eq({tag, ".zero"},      {31'd0, o_zero},      {31'd0, z});
    check_eq({tag, ".rd"},        {27'd0, o_rd},        {27'd0, d});
    check_eq({tag, ".reg_write"}, {31'd0, o_reg_write}, {31'd0, rw});
  endtask

  task automatic drive(input logic v, input logic [2:0] ctl, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] d, input logic rw);
    valid     = v;
    alu_ctl   = ctl;
    src_a     = a;
    src_b     = b;
    rd        = d;
    reg_write = rw;
  endtask

  task automatic set_idle();
    drive(1'b0, ADD, 32'd0, 32'd0, 5'd0, 1'b0);
    stall = 1'b0;
    flush = 1'b0;
  endtask

  // One instruction through an otherwise idle pipeline: checks that nothing
  // shows up one edge after capture and that the full entry shows up after two.
  task automatic run_one(input string tag, input logic v, input logic [2:0] ctl,
                         input logic [31:0] a, input logic [31:0] b, input logic [4:0] d,
                         input logic rw, input logic [31:0] exp_res, input logic exp_zero,
                         input logic exp_v, input logic exp_rw);
    drive(v, ctl, a, b, d, rw);
    @(negedge clk);
    set_idle();
    check_eq({tag, ".early"}, {31'd0, o_valid}, 32'd0);
    @(negedge clk);
    check_out(tag, exp_v, exp_res, exp_zero, d, exp_rw);
    $display("txn %-10s ctl=%0d a=%08h b=%08h rd=%0d -> v=%0b res=%08h z=%0b rd=%0d rw=%0b",
             tag, ctl, a, b, d, o_valid, o_result, o_zero, o_rd, o_reg_write);
  endtask

  initial begin
    rst_n = 1'b0;
    set_idle();
    @(negedge clk);
    @(negedge clk);
    check_out("reset", 1'b0, 32'd0, 1'b0, 5'd0, 1'b0);
    $display("txn reset      outputs v=%0b res=%08h", o_valid, o_result);
    rst_n = 1'b1;

    //       tag          v     ctl   A             B             rd    rw    result        z     v     rw
    run_one("add_wrap",  1'b1, ADD,  32'hFFFFFFFF, 32'h00000001, 5'd5, 1'b1, 32'h00000000, 1'b1, 1'b1, 1'b1);
    run_one("slt_neg",   1'b1, SLT,  32'hFFFFFFFE, 32'h00000003, 5'd1, 1'b1, 32'h00000001, 1'b0, 1'b1, 1'b1);
    run_one("slt_swap",  1'b1, SLT,  32'h00000003, 32'hFFFFFFFE, 5'd2, 1'b1, 32'h00000000, 1'b1, 1'b1, 1'b1);
    run_one("uext",      1'b1, UEXT, 32'hDEADBEEF, 32'h12345000, 5'd3, 1'b1, 32'h12345000, 1'b0, 1'b1, 1'b1);
    run_one("and",       1'b1, AND_, 32'h0000F0F0, 32'h0000FF00, 5'd6, 1'b1, 32'h0000F000, 1'b0, 1'b1, 1'b1);
    run_one("or_x0",     1'b1, OR_,  32'h000000F0, 32'h0000000F, 5'd0, 1'b1, 32'h000000FF, 1'b0, 1'b1, 1'b0);
    run_one("bad_ctl",   1'b1, 3'd7, 32'h00001234, 32'h00005678, 5'd9, 1'b1, 32'h00000000, 1'b1, 1'b1, 1'b1);
    run_one("invalid",   1'b0, ADD,  32'h00000002, 32'h00000003, 5'd4, 1'b1, 32'h00000005, 1'b0, 1'b0, 1'b0);
    run_one("sub_under", 1'b1, SUB,  32'h00000000, 32'h00000001, 5'd8, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0);

    // Stall: SUB 10-3 held for two edges, then emitted exactly once.
    drive(1'b1, SUB, 32'd10, 32'd3, 5'd7, 1'b1);
    @(negedge clk);
    set_idle();
    stall = 1'b1;
    @(negedge clk);
    check_eq("stall.bubble1", {31'd0, o_valid}, 32'd0);
    @(negedge clk);
    check_eq("stall.bubble2", {31'd0, o_valid}, 32'd0);
    stall = 1'b0;
    @(negedge clk);
    check_out("stall.out", 1'b1, 32'd7, 1'b0, 5'd7, 1'b1);
    $display("txn stall      released -> v=%0b res=%08h rd=%0d", o_valid, o_result, o_rd);
    @(negedge clk);
    check_eq("stall.once", {31'd0, o_valid}, 32'd0);

    // Flush together with stall squashes the AND before it enters ID/EX.
    drive(1'b1, AND_, 32'h000000FF, 32'h0000000F, 5'd11, 1'b1);
    stall = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    set_idle();
    @(negedge clk);
    check_eq("flush.v1",  {31'd0, o_valid}, 32'd0);
    check_eq("flush.rd1", {27'd0, o_rd},    32'd0);
    @(negedge clk);
    check_eq("flush.v2",  {31'd0, o_valid}, 32'd0);
    check_eq("flush.rd2", {27'd0, o_rd},    32'd0);
    $display("txn flush      and squashed -> v=%0b rd=%0d", o_valid, o_rd);

    // Reset with one instruction in ID/EX and another at the inputs.
    drive(1'b1, ADD, 32'd1, 32'd1, 5'd3, 1'b1);
    @(negedge clk);
    drive(1'b1, SUB, 32'd5, 32'd1, 5'd4, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    check_out("rst_mid", 1'b0, 32'd0, 1'b0, 5'd0, 1'b0);
    rst_n = 1'b1;
    set_idle();
    @(negedge clk);
    check_eq("rst_mid.after1", {31'd0, o_valid}, 32'd0);
    @(negedge clk);
    check_eq("rst_mid.after2", {31'd0, o_valid}, 32'd0);
    $display("txn rst_mid    in-flight dropped -> v=%0b", o_valid);

    // Reset during a stall discards the held instruction.
    drive(1'b1, OR_, 32'h00000001, 32'h00000002, 5'd12, 1'b1);
    @(negedge clk);
    set_idle();
    stall = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    stall = 1'b0;
    @(negedge clk);
    check_eq("rst_stall.v",  {31'd0, o_valid}, 32'd0);
    check_eq("rst_stall.rd", {27'd0, o_rd},    32'd0);
    $display("txn rst_stall  held dropped -> v=%0b rd=%0d", o_valid, o_rd);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
